ysyx_24080034_ifu: RTL and testbench

//   Instruction fetch unit: upstream of the single-cycle decode/execute datapath.
//   - Owns the PC and sends one fetch at a time to instruction memory over a valid/ready request channel.
//   - Accepts a variable-latency response and presents {inst, pc} to decode over a valid/ready channel.
//   - Accepts a redirect (branch/jump target) from downstream and discards the stale fetch it replaces.

---
 rtl/ysyx_24080034_ifu.sv | 115 +++++++++++
 tb/tb_ysyx_24080034_ifu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080034_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to instruction memory,
// and hands {inst, pc} to decode. Redirects from downstream cancel a stale fetch that is still in flight.
module ysyx_24080034_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic        r_req_valid;
  logic        r_inst_valid;
  logic [31:0] r_inst_data;
  logic [31:0] r_inst_pc;

  logic [31:0] w_redirect_pc;
  logic        w_req_fire;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_req_fire    = r_req_valid && imem_req_ready;

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;

  // req_valid is a registered copy of (state == REQ), so it stays low for the
  // first REQ cycle after reset and only a registered handshake can leave REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
      r_inst_pc    <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_req_fire) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
            if (redirect_valid) begin
              r_pc   <= w_redirect_pc;
              r_drop <= 1'b1;
            end
          end else begin
            r_req_valid <= 1'b1;
            if (redirect_valid) r_pc <= w_redirect_pc;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (imem_resp_valid) begin
              r_drop      <= 1'b0;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (r_drop) begin
              r_drop      <= 1'b0;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_inst_data  <= imem_resp_data;
              r_inst_pc    <= r_pc;
              r_inst_valid <= 1'b1;
              r_state      <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (redirect_valid || inst_ready) begin
            r_pc         <= redirect_valid ? w_redirect_pc : r_pc + 32'(PC_STEP);
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_REQ;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
          r_drop       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080034_ifu.sv
// Directed testbench for the instruction fetch unit: sequential fetch, stalls,
// redirects in every state, reset mid-transaction and PC wrap-around.
module tb_ysyx_24080034_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int unsigned n_cmp;
  int unsigned n_err;

  ysyx_24080034_ifu #(
    .RESET_PC(32'h8000_0000),
    .PC_STEP (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
    n_cmp++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL rst_inst_data got %h want 0", inst_data); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc got %h want 0", inst_pc); end
    n_cmp++; if (imem_req_addr !== 32'h8000_0000) begin n_err++; $display("FAIL rst_addr got %h want 80000000", imem_req_addr); end
    rst = 1'b0;
    tick();
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_req_valid got %b want 1", imem_req_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h0000_0093; words[1] = 32'h0010_0113; words[2] = 32'h0020_0193;
    for (int k = 0; k < 3; k++) begin
      imem_req_ready = 1'b1; inst_ready = 1'b1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 + 32'(4 * k)) begin
        n_err++; $display("FAIL seq_req[%0d] got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, 32'h8000_0000 + 32'(4 * k)); end
      tick();
      imem_req_ready = 1'b0;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL seq_wait_req[%0d] got %b want 0", k, imem_req_valid); end
      imem_resp_valid = 1'b1; imem_resp_data = words[k];
      tick();
      imem_resp_valid = 1'b0;
      n_cmp++; if (inst_valid !== 1'b1 || inst_data !== words[k] || inst_pc !== 32'h8000_0000 + 32'(4 * k)) begin
        n_err++; $display("FAIL seq_out[%0d] got v=%b d=%h pc=%h want v=1 d=%h pc=%h", k, inst_valid, inst_data, inst_pc, words[k], 32'h8000_0000 + 32'(4 * k)); end
      tick();
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL seq_consumed[%0d] got %b want 0", k, inst_valid); end
    end
  endtask

  task automatic test_stall();
    inst_ready = 1'b0; imem_req_ready = 1'b1;
    n_cmp++; if (imem_req_addr !== 32'h8000_000C) begin n_err++; $display("FAIL stall_addr got %h want 8000000c", imem_req_addr); end
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_err++; $display("FAIL stall_wait[%0d] got req=%b iv=%b want 0 0", i, imem_req_valid, inst_valid); end
    end
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    tick();
    imem_resp_valid = 1'b0; imem_resp_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (inst_valid !== 1'b1 || inst_data !== 32'h1234_5678 || inst_pc !== 32'h8000_000C || imem_req_valid !== 1'b0) begin
        n_err++; $display("FAIL stall_hold[%0d] got v=%b d=%h pc=%h req=%b want 1 12345678 8000000c 0", i, inst_valid, inst_data, inst_pc, imem_req_valid); end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0010) begin
      n_err++; $display("FAIL stall_done got iv=%b req=%b a=%h want 0 1 80000010", inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdw_still_wait got %b want 0", imem_req_valid); end
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
      n_err++; $display("FAIL rdw_drop got iv=%b d=%h req=%b a=%h want 0 - 1 80000100", inst_valid, inst_data, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hA0A0_A0A0;
    tick();
    imem_resp_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b1 || inst_data !== 32'hA0A0_A0A0 || inst_pc !== 32'h8000_0100) begin
      n_err++; $display("FAIL rdw_refetch got v=%b d=%h pc=%h want 1 a0a0a0a0 80000100", inst_valid, inst_data, inst_pc); end
  endtask

  task automatic test_redirect_out();
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0203;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
      n_err++; $display("FAIL rdo_next got iv=%b req=%b a=%h want 0 1 80000200", inst_valid, imem_req_valid, imem_req_addr); end
    tick();
    inst_ready = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || imem_req_addr !== 32'h8000_0200) begin
      n_err++; $display("FAIL rdo_once got iv=%b a=%h want 0 80000200", inst_valid, imem_req_addr); end
  endtask

  task automatic test_req_stall_redirect();
    imem_req_ready = 1'b0;
    tick();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
      n_err++; $display("FAIL rqs_c1 got v=%b a=%h want 1 80000200", imem_req_valid, imem_req_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    #2;
    n_cmp++; if (imem_req_addr !== 32'h8000_0200) begin n_err++; $display("FAIL rqs_c2 got %h want 80000200", imem_req_addr); end
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin
      n_err++; $display("FAIL rqs_c3 got v=%b a=%h want 1 80000300", imem_req_valid, imem_req_addr); end
    tick();
    imem_req_ready = 1'b1;
    tick();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rqs_accept got %b want 0", imem_req_valid); end
    tick();
    imem_req_ready = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rqs_single got %b want 0", imem_req_valid); end
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0055;
    tick();
    imem_resp_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0300 || inst_data !== 32'h0000_0055) begin
      n_err++; $display("FAIL rqs_out got v=%b pc=%h d=%h want 1 80000300 00000055", inst_valid, inst_pc, inst_data); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++; if (imem_req_addr !== 32'h8000_0304) begin n_err++; $display("FAIL rqs_next got %h want 80000304", imem_req_addr); end
  endtask

  task automatic test_reset_in_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; rst = 1'b1;
    tick();
    n_cmp++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL rsw_reset got req=%b iv=%b want 0 0", imem_req_valid, inst_valid); end
    rst = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
    tick();
    imem_resp_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      n_err++; $display("FAIL rsw_ignore got iv=%b req=%b a=%h want 0 1 80000000", inst_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rsw_wait_iv got %b want 0", inst_valid); end
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b1 || inst_data !== 32'h0000_0013 || inst_pc !== 32'h8000_0000) begin
      n_err++; $display("FAIL rsw_fresh got v=%b d=%h pc=%h want 1 00000013 80000000", inst_valid, inst_data, inst_pc); end
  endtask

  task automatic test_wrap_and_wait_redirect_resp();
    // from OUT: redirect to the top word, then fetch it and step past the end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    n_cmp++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got %h want fffffffc", imem_req_addr); end
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0073;
    tick();
    imem_resp_valid = 1'b0; inst_ready = 1'b1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_out got v=%b pc=%h want 1 fffffffc", inst_valid, inst_pc); end
    tick();
    inst_ready = 1'b0;
    n_cmp++; if (imem_req_addr !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pc got %h want 00000000", imem_req_addr); end
    // redirect coinciding with the response in WAIT: response discarded, no lingering drop
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
    tick();
    imem_resp_valid = 1'b0; redirect_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0400) begin
      n_err++; $display("FAIL wrr_req got iv=%b req=%b a=%h want 0 1 80000400", inst_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_2222;
    tick();
    imem_resp_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b1 || inst_data !== 32'h2222_2222 || inst_pc !== 32'h8000_0400) begin
      n_err++; $display("FAIL wrr_nodrop got v=%b d=%h pc=%h want 1 22222222 80000400", inst_valid, inst_data, inst_pc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_out();
    test_req_stall_redirect();
    test_reset_in_wait();
    test_wrap_and_wait_redirect_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
